// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, access owner tag
// and default parameter values.
package mem_pkg;

    localparam int MEM_AW         = 16;
    localparam int MEM_DW         = 32;
    localparam int MEM_LAT        = 1;
    localparam int MEM_STARVE_MAX = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_prio_sel.sv
// Arbitration between fetch and data requesters: data normally wins, but fetch is
// forced through once it has lost STARVE_MAX contested grants in a row.
module mem_prio_sel
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = MEM_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic if_win,
    output logic d_win
);

    localparam int            CW  = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SAT = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          fetch_forced;

    always_comb begin
        fetch_forced = if_req && (starve_cnt == SAT);
        d_win        = arb_en && d_req && !fetch_forced;
        if_win       = arb_en && if_req && !d_win;
    end

    // Only grants that actually kept a waiting fetch out count towards starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_win) begin
            starve_cnt <= '0;
        end else if (d_win && if_req && (starve_cnt != SAT)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one access outstanding at a time, sequenced by an
// IDLE -> BUSY (LAT cycles) -> DONE FSM with per-requester read data registers.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW         = MEM_AW,
    parameter int DW         = MEM_DW,
    parameter int LAT        = MEM_LAT,
    parameter int STARVE_MAX = MEM_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [2:0] LAST_BUSY = 3'(LAT - 1);

    logic [1:0]    state;
    logic [2:0]    busy_cnt;
    owner_t        owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          arb_en;
    logic          if_win;
    logic          d_win;

    assign arb_en = (state == ST_IDLE) && !rst;

    mem_prio_sel #(
        .STARVE_MAX(STARVE_MAX)
    ) u_sel (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
        .if_req (if_req),
        .d_req  (d_req),
        .if_win (if_win),
        .d_win  (d_win)
    );

    // Reset gates the strobes combinationally so an aborted access leaves no trace.
    always_comb begin
        if_gnt  = if_win;
        d_gnt   = d_win;
        if_done = (state == ST_DONE) && (owner == OWN_IF) && !rst;
        d_done  = (state == ST_DONE) && (owner == OWN_D) && !rst;
        m_we    = (state == ST_BUSY) && (busy_cnt == 3'd0) && lat_we && !rst;
        m_addr  = lat_addr;
        m_wdata = lat_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy_cnt <= 3'd0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_win || d_win) begin
                        owner    <= d_win ? OWN_D : OWN_IF;
                        lat_we   <= d_win && d_we;
                        lat_addr <= d_win ? d_addr : if_addr;
                        if (d_win) begin
                            lat_wdata <= d_wdata;
                        end
                        busy_cnt <= 3'd0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (busy_cnt == LAST_BUSY) begin
                        state <= ST_DONE;
                        if (owner == OWN_IF) begin
                            if_rdata <= m_rdata;
                        end else if (!lat_we) begin
                            d_rdata <= m_rdata;
                        end
                    end else begin
                        busy_cnt <= busy_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter (LAT=2, STARVE_MAX=3) with a
// transaction-level reference model and a decoupled completion monitor.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_done;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_done;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    function automatic logic [31:0] seed_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'h00500093 : {8'hA5, a, ~a, 8'h5A};
    endfunction

    // Memory: one registered read stage, so data for the first BUSY address is ready in the last BUSY cycle.
    bit          mem_vld [0:255];
    logic [31:0] mem_val [0:255];
    logic [31:0] rdq;
    always @(posedge clk) begin
        if (m_we) begin
            mem_vld[m_addr[7:0]] <= 1'b1;
            mem_val[m_addr[7:0]] <= m_wdata;
        end
        rdq <= mem_vld[m_addr[7:0]] ? mem_val[m_addr[7:0]] : seed_word(m_addr[7:0]);
    end
    assign m_rdata = rdq;

    typedef struct {
        bit          is_d;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
        int          done_cyc;
    } item_t;
    item_t sb[$];

    bit          ref_vld [0:255];
    logic [31:0] ref_val [0:255];

    bit          pif, pd, pwe;
    logic [15:0] paddr_if, paddr_d;
    logic [31:0] pwdata;
    int          starve, next_free, we_cyc, last_grant, if_g_cyc, d_g_cyc;
    logic [31:0] last_if, last_d, exp_mwdata;
    logic [15:0] exp_maddr;
    bit          exp_ig, exp_dg, check_starve;
    bit          order[$];
    bit          undo_vld;
    logic [7:0]  undo_idx;
    logic [31:0] undo_val;

    function automatic logic [31:0] ref_read(input logic [7:0] a);
        return ref_vld[a] ? ref_val[a] : seed_word(a);
    endfunction

    function automatic void compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic checkOutput();
        compare("if_gnt", 64'(if_gnt), 64'(exp_ig));
        compare("d_gnt", 64'(d_gnt), 64'(exp_dg));
        compare("m_we", 64'(m_we), 64'((cyc == we_cyc) && !rst));
        if (cyc == we_cyc && !rst) compare("m_wdata", 64'(m_wdata), 64'(exp_mwdata));
        if (cyc > last_grant && cyc <= last_grant + LAT) compare("m_addr", 64'(m_addr), 64'(exp_maddr));
    endtask

    // One clock cycle: predict the grant from the arbitration rules, drive, check, record.
    task automatic applyStimulus(input bit do_rst);
        item_t it;
        @(posedge clk);
        #1;
        if (check_starve) begin
            compare("starve_clear", 64'(dut.u_sel.starve_cnt), 64'd0);
            check_starve = 1'b0;
        end
        exp_ig = 1'b0;
        exp_dg = 1'b0;
        if (do_rst) begin
            if (cyc == we_cyc) begin
                ref_vld[undo_idx] = undo_vld;
                ref_val[undo_idx] = undo_val;
            end
            pif = 1'b0; pd = 1'b0; starve = 0; next_free = cyc + 1;
            last_if = '0; last_d = '0; sb.delete(); we_cyc = -1; last_grant = -100;
        end else if (cyc >= next_free && (pif || pd)) begin
            if (pd && !(pif && starve == SMAX)) exp_dg = 1'b1;
            else exp_ig = 1'b1;
        end
        rst = do_rst;
        if_req = pif; if_addr = paddr_if;
        d_req = pd; d_we = pwe; d_addr = paddr_d; d_wdata = pwdata;
        #1;
        checkOutput();
        if (exp_ig || exp_dg) begin
            next_free  = cyc + LAT + 2;
            last_grant = cyc;
            if (exp_ig) begin
                last_if = ref_read(paddr_if[7:0]);
                exp_maddr = paddr_if;
                starve = 0; check_starve = 1'b1; if_g_cyc = cyc; pif = 1'b0;
                order.push_back(1'b0);
            end else begin
                exp_maddr = paddr_d;
                d_g_cyc = cyc;
                if (pwe) begin
                    undo_idx = paddr_d[7:0];
                    undo_vld = ref_vld[undo_idx];
                    undo_val = ref_val[undo_idx];
                    ref_vld[undo_idx] = 1'b1;
                    ref_val[undo_idx] = pwdata;
                    exp_mwdata = pwdata;
                    we_cyc = cyc + 1;
                end else begin
                    last_d = ref_read(paddr_d[7:0]);
                end
                if (pif && starve < SMAX) starve++;
                pd = 1'b0;
                order.push_back(1'b1);
            end
            it.is_d = exp_dg; it.exp_if = last_if; it.exp_d = last_d; it.done_cyc = cyc + LAT + 1;
            sb.push_back(it);
        end
    endtask

    task automatic waitGrant();
        for (int i = 0; i < 20 && (pif || pd); i++) applyStimulus(1'b0);
        if (pif || pd) begin
            n_checks++;
            $display("[TB] FAIL grant_timeout: pending if=%0b d=%0b, expected a grant within 20 cycles", pif, pd);
            pif = 1'b0; pd = 1'b0;
        end
    endtask

    task automatic raiseIf();
        if (!pif) begin pif = 1'b1; paddr_if = 16'($urandom) & 16'hFF7F; end
    endtask

    task automatic raiseD();
        if (!pd) begin
            pd = 1'b1; pwe = 1'($urandom_range(1));
            paddr_d = 16'($urandom) & 16'hFF7F; pwdata = $urandom;
        end
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
            n_checks++;
            $display("[TB] FAIL done_missing: none by cycle %0d, expected at %0d", cyc, sb[0].done_cyc);
            sb.delete(0);
        end
        if (if_done || d_done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL done_unexpected: if_done=%b d_done=%b at cycle %0d, expected none", if_done, d_done, cyc);
            end else begin
                it = sb.pop_front();
                compare("done_owner_d", 64'(d_done), 64'(it.is_d));
                compare("done_owner_if", 64'(if_done), 64'(!it.is_d));
                compare("done_cycle", 64'(cyc), 64'(it.done_cyc));
                compare("if_rdata", 64'(if_rdata), 64'(it.exp_if));
                compare("d_rdata", 64'(d_rdata), 64'(it.exp_d));
            end
        end
    end

    initial begin : stim
        logic [7:0] got;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        pif = 1'b0; pd = 1'b0; pwe = 1'b0; paddr_if = '0; paddr_d = '0; pwdata = '0;
        starve = 0; next_free = 0; we_cyc = -1; last_grant = -100; if_g_cyc = 0; d_g_cyc = 0;
        last_if = '0; last_d = '0; exp_mwdata = '0; exp_maddr = '0; check_starve = 1'b0;

        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        compare("rst_if_rdata", 64'(if_rdata), 64'd0);
        compare("rst_d_rdata", 64'(d_rdata), 64'd0);
        compare("rst_done", 64'({if_done, d_done}), 64'd0);

        pif = 1'b1; paddr_if = 16'h0010;
        waitGrant();
        repeat (5) applyStimulus(1'b0);
        compare("lone_fetch_rdata", 64'(if_rdata), 64'h00500093);

        pd = 1'b1; pwe = 1'b1; paddr_d = 16'h0040; pwdata = 32'hDEADBEEF;
        waitGrant();
        repeat (4) applyStimulus(1'b0);
        pd = 1'b1; pwe = 1'b0;
        waitGrant();
        repeat (4) applyStimulus(1'b0);
        compare("load_after_store", 64'(d_rdata), 64'hDEADBEEF);

        order.delete();
        for (int i = 0; i < 36; i++) begin
            raiseIf();
            raiseD();
            applyStimulus(1'b0);
        end
        repeat (14) applyStimulus(1'b0);
        got = '0;
        for (int k = 0; k < 8; k++) got[7-k] = (order.size() > k) ? order[k] : 1'b0;
        compare("contention_order", 64'(got), 64'hEE);

        pif = 1'b1; paddr_if = 16'h0020;
        waitGrant();
        applyStimulus(1'b0);
        pd = 1'b1; pwe = 1'b0; paddr_d = 16'h0030;
        waitGrant();
        compare("busy_ignore_gap", 64'(d_g_cyc - if_g_cyc), 64'(LAT + 2));
        repeat (4) applyStimulus(1'b0);

        pd = 1'b1; pwe = 1'b1; paddr_d = 16'h00F0; pwdata = 32'h12345678;
        waitGrant();
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        compare("abort_if_rdata", 64'(if_rdata), 64'd0);
        compare("abort_d_rdata", 64'(d_rdata), 64'd0);
        compare("abort_d_done", 64'(d_done), 64'd0);
        compare("abort_state", 64'(dut.state), 64'd0);
        repeat (6) applyStimulus(1'b0);
        compare("abort_no_write", 64'(mem_vld[8'hF0]), 64'd0);

        for (int i = 0; i < 600; i++) begin
            if (!pif && $urandom_range(2) == 0) raiseIf();
            if (!pd && $urandom_range(1) == 0) raiseD();
            applyStimulus($urandom_range(149) == 0);
        end
        repeat (14) applyStimulus(1'b0);
        compare("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 16, address width of both requesters and the memory port.
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: LAT, 1, memory read latency in cycles (1..7); m_rdata is valid LAT cycles after the address is applied.
REQ-004 Parameter: STARVE_MAX, 3, consecutive contested data grants before fetch is forced through (1..15).
REQ-005 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Ports, fetch requester:
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch address (pc).
- if_gnt  out  1  request accepted this cycle.
- if_done  out  1  one-cycle completion pulse.
- if_rdata  out  DW  instruction word, valid with if_done.
REQ-008 Ports, data requester:
- d_req  in  1  load/store request.
- d_we  in  1  store when high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  request accepted.
- d_done  out  1  one-cycle completion pulse, loads and stores.
- d_rdata  out  DW  load data, valid with d_done.
REQ-009 Ports, memory side:
- m_we  out  1  write strobe.
- m_addr  out  AW  address.
- m_wdata  out  DW  write data.
- m_rdata  in  DW  read data.

Function
REQ-010 The FSM SHALL have states IDLE, BUSY and DONE; only one access is outstanding at any time.
REQ-011 In IDLE with any request high, the arbiter SHALL assert exactly one gnt combinationally in that cycle, then latch owner, addr, we and wdata at the clock edge and enter BUSY.
REQ-012 Arbitration SHALL give data priority over fetch, except when starve_cnt == STARVE_MAX and if_req is high; fetch then wins.
REQ-013 starve_cnt SHALL increment on each data grant made while if_req is high, clear on any fetch grant, and saturate at STARVE_MAX.
REQ-014 BUSY SHALL last exactly LAT cycles.
- m_addr and m_wdata SHALL be driven from the latched values throughout BUSY.
- m_we SHALL be high only in the first BUSY cycle, and only for a latched store.
REQ-015 On the last BUSY cycle, m_rdata SHALL be registered into the owner's rdata register, and the FSM SHALL enter DONE.
REQ-016 In DONE, the owner's done output SHALL pulse high for one cycle; the FSM SHALL then return to IDLE, with no grant issued in DONE.
REQ-017 Gnt-to-done latency SHALL be LAT+1 cycles; minimum spacing between grants SHALL be LAT+2 cycles.
REQ-018 if_rdata and d_rdata SHALL hold their last value until the next completion of the same requester; store completions SHALL leave d_rdata unchanged.
REQ-019 Requests raised while not in IDLE SHALL be ignored, with gnt held low; requesters keep req and operands stable until gnt.
REQ-020 When no access is active, m_we SHALL be 0 and m_addr/m_wdata SHALL hold their last values.

Reset
REQ-021 While rst is high at a clock edge, the next state SHALL be:
- state = IDLE, starve_cnt = 0;
- if_rdata = 0, d_rdata = 0;
- all gnt, done and m_we outputs = 0.
REQ-022 Reset during BUSY or DONE SHALL abort the access with no done pulse and no retry.
REQ-023 A store whose m_we cycle coincides with rst high SHALL have m_we forced to 0.

Structure
REQ-024 State encoding and default parameter constants SHALL live in shared package mem_pkg.
REQ-025 The arbitration decision, including the starvation counter, SHALL be the sub-module mem_prio_sel; the FSM and datapath registers stay in mem_arbiter.

Verification (LAT=2, STARVE_MAX=3)
REQ-026 Lone fetch: if_req=1, if_addr=0x0010, memory word 0x00500093 -> if_gnt at cycle 0, if_done at cycle 3, if_rdata=0x00500093.
REQ-027 Store then load: d_we=1, d_addr=0x0040, d_wdata=0xDEADBEEF -> m_we high for exactly one cycle, d_done at cycle 3; a following load of 0x0040 returns d_rdata=0xDEADBEEF.
REQ-028 Contention: if_req and d_req held high continuously -> grant order D,D,D,I,D,D,D,I; starve_cnt reads 0 after each I grant.
REQ-029 Mid-access reset: rst pulsed in the first BUSY cycle of a store -> m_we=0, no d_done, state IDLE, outputs 0 on the next cycle.
REQ-030 Busy ignore: d_req raised during a fetch's BUSY -> d_gnt stays 0 until the IDLE cycle after if_done, then d_gnt=1.
